// File: rtl/activation_window_gen_if.sv
// Stream and window interface for activation_window_gen.
// The optional win_cnt signal exists only when AWG_WIN_CNT_EN is defined.
interface activation_window_gen_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 hold;
  logic [WIDTH-1:0]     in_pix;
  logic                 in_vld;
  logic                 in_rdy;
  logic [3*WIDTH-1:0]   activate0;
  logic [3*WIDTH-1:0]   activate1;
  logic [3*WIDTH-1:0]   activate2;
  logic                 activate_ready;
  logic                 frame_done;
`ifdef AWG_WIN_CNT_EN
  logic [15:0]          win_cnt;
`endif

  // Pixel source and window consumer side
  modport master (
`ifdef AWG_WIN_CNT_EN
    input  win_cnt,
`endif
    output start, hold, in_pix, in_vld,
    input  in_rdy, activate0, activate1, activate2, activate_ready, frame_done
  );

  // Window generator side
  modport slave (
`ifdef AWG_WIN_CNT_EN
    output win_cnt,
`endif
    input  start, hold, in_pix, in_vld,
    output in_rdy, activate0, activate1, activate2, activate_ready, frame_done
  );
endinterface

// File: rtl/activation_window_gen.sv
// activation_window_gen: turns a raster-order pixel stream into 3x3 sliding
// windows (stride 1, no padding) for computing_core. Two line buffers hold the
// previous two image rows; three 3-pixel shift registers form the window.
// Optional feature macro: AWG_WIN_CNT_EN adds a 16-bit per-frame window counter.
module activation_window_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  activation_window_gen_if.slave  bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [1:0]          state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;

  logic [WIDTH-1:0]    lb_top [IMG_W];
  logic [WIDTH-1:0]    lb_mid [IMG_W];

  logic [3*WIDTH-1:0]  win_top;
  logic [3*WIDTH-1:0]  win_mid;
  logic [3*WIDTH-1:0]  win_bot;
  logic [3*WIDTH-1:0]  next_top;
  logic [3*WIDTH-1:0]  next_mid;
  logic [3*WIDTH-1:0]  next_bot;

  logic [3*WIDTH-1:0]  act0_q;
  logic [3*WIDTH-1:0]  act1_q;
  logic [3*WIDTH-1:0]  act2_q;
  logic                act_rdy_q;

  logic                rdy;
  logic                xfer;
  logic                last_pix;
  logic                win_valid;
  logic [WIDTH-1:0]    top_pix;
  logic [WIDTH-1:0]    mid_pix;

  assign rdy       = (state == RUN) & ~bus.hold;
  assign xfer      = bus.in_vld & rdy;
  assign last_pix  = (col == COL_LAST) && (row == ROW_LAST);
  // Window is complete only once two full rows are buffered and the current
  // row has supplied three columns, so row-spanning windows never qualify.
  assign win_valid = (col >= COL_TWO) && (row >= ROW_TWO);

  assign top_pix  = lb_top[col];
  assign mid_pix  = lb_mid[col];
  assign next_top = {win_top[2*WIDTH-1:0], top_pix};
  assign next_mid = {win_mid[2*WIDTH-1:0], mid_pix};
  assign next_bot = {win_bot[2*WIDTH-1:0], bus.in_pix};

  assign bus.in_rdy         = rdy;
  assign bus.activate0      = act0_q;
  assign bus.activate1      = act1_q;
  assign bus.activate2      = act2_q;
  assign bus.activate_ready = act_rdy_q;
  assign bus.frame_done     = (state == DONE);

  // Frame sequencing and raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (last_pix) begin
              state <= DONE;
            end
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_ONE;
            end else begin
              col <= col + COL_ONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Line buffers age each column by one row; contents are always rewritten before use
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb_top[col] <= mid_pix;
      lb_mid[col] <= bus.in_pix;
    end
  end

  // Window shift registers advance on every accepted pixel, valid or not
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_top <= '0;
      win_mid <= '0;
      win_bot <= '0;
    end else if (xfer) begin
      win_top <= next_top;
      win_mid <= next_mid;
      win_bot <= next_bot;
    end
  end

  // Publish a complete window one cycle after the pixel that completes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      act0_q    <= '0;
      act1_q    <= '0;
      act2_q    <= '0;
      act_rdy_q <= 1'b0;
    end else begin
      act_rdy_q <= xfer & win_valid;
      if (xfer && win_valid) begin
        act0_q <= next_top;
        act1_q <= next_mid;
        act2_q <= next_bot;
      end
    end
  end

`ifdef AWG_WIN_CNT_EN
  logic [15:0] win_cnt_q;

  assign bus.win_cnt = win_cnt_q;

  // Count windows of the current frame, updating together with activate_ready
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_cnt_q <= '0;
    end else if (state == IDLE && bus.start) begin
      win_cnt_q <= '0;
    end else if (xfer && win_valid) begin
      win_cnt_q <= win_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_activation_window_gen.sv
// Self-checking bench for activation_window_gen (8x8 image, 8-bit pixels,
// pixel n carries value n). A small reference model predicts acceptance,
// window contents, pulses and frame_done for every cycle.
module tb_activation_window_gen;

  localparam int WIDTH = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int NPIX  = IMG_W * IMG_H;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk;
  logic rst;

  activation_window_gen_if #(.WIDTH(WIDTH)) bus ();

  activation_window_gen #(
    .WIDTH(WIDTH),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int check_count = 0;
  int error_count = 0;

  int          m_state = M_IDLE;
  int          m_n     = 0;
  int          m_cnt   = 0;
  logic        exp_ready = 1'b0;
  logic        exp_done  = 1'b0;
  logic [23:0] exp_a0 = '0;
  logic [23:0] exp_a1 = '0;
  logic [23:0] exp_a2 = '0;
  int          pulse_seen = 0;
  int          done_seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [23:0] winRow(input int last);
    return {8'(last - 2), 8'(last - 1), 8'(last)};
  endfunction

  // Drive one cycle (called at a negedge), predict its effect, check outputs at next negedge
  task automatic applyStimulus(input logic st, input logic vld, input logic hld,
                               input logic rs);
    logic xfer_m;
    int   n;
    int   r;
    int   c;
    rst        = rs;
    bus.start  = st;
    bus.hold   = hld;
    bus.in_vld = vld;
    bus.in_pix = 8'(m_n);
    #1;
    checkOutput("in_rdy", 64'(bus.in_rdy), 64'(m_state == M_RUN && !hld));
    xfer_m    = (m_state == M_RUN) && vld && !hld;
    exp_ready = 1'b0;
    exp_done  = 1'b0;
    if (!rs) begin
      m_state = M_IDLE;
      m_cnt   = 0;
      exp_a0  = '0;
      exp_a1  = '0;
      exp_a2  = '0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (st) begin
            m_state = M_RUN;
            m_n     = 0;
            m_cnt   = 0;
          end
        end
        M_RUN: begin
          if (xfer_m) begin
            n = m_n;
            r = n / IMG_W;
            c = n % IMG_W;
            if (r >= 2 && c >= 2) begin
              exp_ready = 1'b1;
              exp_a2    = winRow(n);
              exp_a1    = winRow(n - IMG_W);
              exp_a0    = winRow(n - 2 * IMG_W);
              m_cnt++;
            end
            m_n++;
            if (n == NPIX - 1) begin
              m_state  = M_DONE;
              exp_done = 1'b1;
            end
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
    @(negedge clk);
    checkOutput("activate_ready", 64'(bus.activate_ready), 64'(exp_ready));
    checkOutput("frame_done", 64'(bus.frame_done), 64'(exp_done));
    checkOutput("activate0", 64'(bus.activate0), 64'(exp_a0));
    checkOutput("activate1", 64'(bus.activate1), 64'(exp_a1));
    checkOutput("activate2", 64'(bus.activate2), 64'(exp_a2));
`ifdef AWG_WIN_CNT_EN
    checkOutput("win_cnt", 64'(bus.win_cnt), 64'(m_cnt));
`endif
    if (bus.activate_ready === 1'b1) pulse_seen++;
    if (bus.frame_done === 1'b1) done_seen++;
  endtask

  // Stream pixels until the model has accepted 'target' pixels
  task automatic streamTo(input int target, input bit gaps, input bit poke_start);
    int cyc;
    bit vld;
    cyc = 0;
    vld = 1'b1;
    while (m_n < target && cyc < 400) begin
      applyStimulus(poke_start && (cyc % 5 == 3), vld, 1'b0, 1'b1);
      if (gaps) vld = !vld;
      cyc++;
    end
    if (m_n < target) checkOutput("stream_timeout", 64'(m_n), 64'(target));
  endtask

  task automatic startFrame();
    pulse_seen = 0;
    done_seen  = 0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic finishFrame(input string tag);
    checkOutput({tag, "_pulses"}, 64'(pulse_seen), 64'd36);
    checkOutput({tag, "_done_count"}, 64'(done_seen), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.hold   = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_pix = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_in_rdy", 64'(bus.in_rdy), 64'd0);
    checkOutput("reset_ready", 64'(bus.activate_ready), 64'd0);
    checkOutput("reset_act2", 64'(bus.activate2), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);

    // first window and full frame
    $display("[TB] full frame");
    startFrame();
    streamTo(19, 1'b0, 1'b0);
    checkOutput("first_ready", 64'(bus.activate_ready), 64'd1);
    checkOutput("first_pulses", 64'(pulse_seen), 64'd1);
    checkOutput("first_a0", 64'(bus.activate0), 64'h000102);
    checkOutput("first_a1", 64'(bus.activate1), 64'h08090A);
    checkOutput("first_a2", 64'(bus.activate2), 64'h101112);
    streamTo(NPIX, 1'b0, 1'b0);
    checkOutput("last_done", 64'(bus.frame_done), 64'd1);
    checkOutput("last_a0", 64'(bus.activate0), 64'h2D2E2F);
    checkOutput("last_a1", 64'(bus.activate1), 64'h353637);
    checkOutput("last_a2", 64'(bus.activate2), 64'h3D3E3F);
`ifdef AWG_WIN_CNT_EN
    checkOutput("last_win_cnt", 64'(bus.win_cnt), 64'd36);
`endif
    finishFrame("full");

    // stall after pixel 20
    $display("[TB] hold stall");
    startFrame();
    streamTo(21, 1'b0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    streamTo(22, 1'b0, 1'b0);
    checkOutput("stall_ready", 64'(bus.activate_ready), 64'd1);
    checkOutput("stall_a0", 64'(bus.activate0), 64'h030405);
    checkOutput("stall_a1", 64'(bus.activate1), 64'h0B0C0D);
    checkOutput("stall_a2", 64'(bus.activate2), 64'h131415);
    streamTo(NPIX, 1'b0, 1'b0);
    finishFrame("stall");

    // in_vld toggling every cycle
    $display("[TB] valid gaps");
    startFrame();
    streamTo(NPIX, 1'b1, 1'b0);
    finishFrame("gaps");

    // reset mid-frame, then a clean frame with start poked during RUN
    $display("[TB] mid-frame reset");
    startFrame();
    streamTo(31, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_act0", 64'(bus.activate0), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    startFrame();
    streamTo(19, 1'b0, 1'b1);
    checkOutput("restart_ready", 64'(bus.activate_ready), 64'd1);
    checkOutput("restart_a0", 64'(bus.activate0), 64'h000102);
    checkOutput("restart_a1", 64'(bus.activate1), 64'h08090A);
    checkOutput("restart_a2", 64'(bus.activate2), 64'h101112);
    streamTo(NPIX, 1'b0, 1'b1);
    finishFrame("restart");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
